// File: rtl/tb_csr_pkg.sv
// Shared definitions for the testbench control/status register bank:
// word addresses, CTRL bit positions, filter register indices, the
// operand word-count helper and the reset-pulse FSM state type.
package tb_csr_pkg;

    // Word addresses of the fixed registers.
    localparam logic [7:0] CTRL_ADDR      = 8'h00;
    localparam logic [7:0] STATUS_ADDR    = 8'h01;
    localparam logic [7:0] SYSVER_ADDR    = 8'h02;
    localparam logic [7:0] CHSEL_ADDR     = 8'h03;
    localparam logic [7:0] DATCTR_LO_ADDR = 8'h04;
    localparam logic [7:0] DATCTR_HI_ADDR = 8'h05;
    localparam logic [7:0] ERRCTR_LO_ADDR = 8'h06;
    localparam logic [7:0] ERRCTR_HI_ADDR = 8'h07;
    localparam logic [7:0] DUTDELAY_ADDR  = 8'h08;
    localparam logic [7:0] FSELECT_ADDR   = 8'h09;

    // Filter operand window: register r, word w lives at FILT_BASE + FILT_STRIDE*r + w.
    localparam logic [7:0] FILT_BASE   = 8'h10;
    localparam int         FILT_STRIDE = 8;
    localparam int         NUM_FILT    = 6;

    // CTRL bit positions.
    localparam int CTRL_RST_BIT = 0;
    localparam int CTRL_EN_BIT  = 1;
    localparam int CTRL_FRZ_BIT = 2;

    // Filter register indices.
    localparam int FILT_MANUAL_A = 0;
    localparam int FILT_MANUAL_B = 1;
    localparam int FILT_BITSET_A = 2;
    localparam int FILT_BITSET_B = 3;
    localparam int FILT_BITCLR_A = 4;
    localparam int FILT_BITCLR_B = 5;

    // Reset pulse generator states.
    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

    // Number of 32-bit bus words needed to hold a WIDTH-bit operand.
    function automatic int nw(input int width);
        return (width + 31) / 32;
    endfunction

    // Expand 4 byte enables into a 32-bit lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/tb_rst_pulse.sv
// Self-timed testbench reset pulse generator.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   trigger     - start (or restart) a pulse of RST_CYCLES cycles
//   pulse       - testbench reset output, high while the pulse runs
//   active      - pulse-in-progress status (CTRL bit0 read value)
module tb_rst_pulse
    import tb_csr_pkg::*;
#(
    parameter int RST_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic pulse,
    output logic active
);

    localparam int             CW     = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(RST_CYCLES);
    localparam logic [CW-1:0]  ONE    = CW'(1);
    localparam logic [CW-1:0]  ZERO   = CW'(0);

    pulse_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // State and down-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PULSE_IDLE;
            cnt_q   <= ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a trigger while pulsing reloads the counter to extend the pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PULSE_IDLE: begin
                if (trigger) begin
                    state_d = PULSE_ACTIVE;
                    cnt_d   = RELOAD;
                end else begin
                    state_d = PULSE_IDLE;
                end
            end
            PULSE_ACTIVE: begin
                if (trigger) begin
                    cnt_d = RELOAD;
                end else if (cnt_q == ONE) begin
                    state_d = PULSE_IDLE;
                    cnt_d   = ZERO;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = PULSE_IDLE;
                cnt_d   = ZERO;
            end
        endcase
    end

    assign pulse  = (state_q == PULSE_ACTIVE);
    assign active = (state_q == PULSE_ACTIVE);

endmodule

// File: rtl/tb_csr_bank.sv
// Avalon-MM register bank controlling and observing the arithmetic testbench.
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   slave_*               - Avalon-MM slave (word address, strobes, byte enables,
//                           registered read data with one-cycle readdatavalid)
//   tb_reset/enable/freeze- testbench control outputs
//   i_data_ctr/i_event_ctr- per-channel 64-bit counters, channel c at [c*64 +: 64]
//   i_dut_delay           - measured DUT delay
//   i_err_pulse           - per-channel error events feeding sticky STATUS flags
//   o_fselect, o_f*       - filter select and WIDTH-bit filter operands
module tb_csr_bank
    import tb_csr_pkg::*;
#(
    parameter int SYS_VERSION = 21,
    parameter int WIDTH       = 64,
    parameter int NUM_CH      = 4,
    parameter int RST_CYCLES  = 8,
    parameter int ADDR_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     slave_address,
    input  logic                  slave_read,
    input  logic                  slave_write,
    input  logic [31:0]           slave_writedata,
    input  logic [3:0]            slave_byteenable,
    output logic [31:0]           slave_readdata,
    output logic                  slave_readdatavalid,
    output logic                  tb_reset,
    output logic                  tb_enable,
    output logic                  tb_freeze,
    input  logic [NUM_CH*64-1:0]  i_data_ctr,
    input  logic [NUM_CH*64-1:0]  i_event_ctr,
    input  logic [31:0]           i_dut_delay,
    input  logic [NUM_CH-1:0]     i_err_pulse,
    output logic                  o_fselect,
    output logic [WIDTH-1:0]      o_fmanual_a,
    output logic [WIDTH-1:0]      o_fmanual_b,
    output logic [WIDTH-1:0]      o_fbitset_a,
    output logic [WIDTH-1:0]      o_fbitset_b,
    output logic [WIDTH-1:0]      o_fbitclr_a,
    output logic [WIDTH-1:0]      o_fbitclr_b
);

    localparam int NWORDS = nw(WIDTH);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CTRL_ADDR);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(STATUS_ADDR);
    localparam logic [ADDR_W-1:0] A_SYSVER = ADDR_W'(SYSVER_ADDR);
    localparam logic [ADDR_W-1:0] A_CHSEL  = ADDR_W'(CHSEL_ADDR);
    localparam logic [ADDR_W-1:0] A_DLO    = ADDR_W'(DATCTR_LO_ADDR);
    localparam logic [ADDR_W-1:0] A_DHI    = ADDR_W'(DATCTR_HI_ADDR);
    localparam logic [ADDR_W-1:0] A_ELO    = ADDR_W'(ERRCTR_LO_ADDR);
    localparam logic [ADDR_W-1:0] A_EHI    = ADDR_W'(ERRCTR_HI_ADDR);
    localparam logic [ADDR_W-1:0] A_DELAY  = ADDR_W'(DUTDELAY_ADDR);
    localparam logic [ADDR_W-1:0] A_FSEL   = ADDR_W'(FSELECT_ADDR);
    localparam logic [ADDR_W-1:0] A_FILT   = ADDR_W'(FILT_BASE);

    // Bus qualification and decode.
    logic              rd_s, wr_s, trig_s, pulse_s, active_s;
    logic [31:0]       mask_s, rdata_s, fword_s;
    logic [NUM_CH-1:0] clr_s;
    logic [63:0]       dat_sel_s, err_sel_s;
    logic [ADDR_W-1:0] foff_s;
    logic              filt_hit_s;
    int                filt_r_s, filt_w_s, ch_s;
    logic [WIDTH-1:0]      frow_s;
    logic [NWORDS*32-1:0]  fpad_s;

    // Registers.
    logic              en_q, en_d, frz_q, frz_d, fsel_q, fsel_d;
    logic [3:0]        chsel_q, chsel_d;
    logic [NUM_CH-1:0] flags_q, flags_d;
    logic [31:0]       dat_hi_q, dat_hi_d, err_hi_q, err_hi_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [WIDTH-1:0]  filt_q [NUM_FILT];
    logic [WIDTH-1:0]  filt_d [NUM_FILT];

    assign rd_s   = slave_read & ~slave_write;
    assign wr_s   = slave_write & ~slave_read;
    assign mask_s = lane_mask(slave_byteenable);
    assign trig_s = wr_s & (slave_address == A_CTRL) & slave_byteenable[0]
                  & slave_writedata[CTRL_RST_BIT];

    tb_rst_pulse #(.RST_CYCLES(RST_CYCLES)) u_rst_pulse (
        .clk     (clk),
        .reset   (reset),
        .trigger (trig_s),
        .pulse   (pulse_s),
        .active  (active_s)
    );

    // Filter window decode and channel selection (out-of-range CHSEL falls back to channel 0).
    always_comb begin
        foff_s     = slave_address - A_FILT;
        filt_r_s   = int'(foff_s) / FILT_STRIDE;
        filt_w_s   = int'(foff_s) % FILT_STRIDE;
        filt_hit_s = (slave_address >= A_FILT) && (filt_r_s < NUM_FILT) && (filt_w_s < NWORDS);
        if (int'(chsel_q) < NUM_CH) begin
            ch_s = int'(chsel_q);
        end else begin
            ch_s = 0;
        end
        dat_sel_s = i_data_ctr[ch_s*64 +: 64];
        err_sel_s = i_event_ctr[ch_s*64 +: 64];
    end

    // Filter read word: pick the row, zero-pad to whole words, pick the word.
    always_comb begin
        frow_s = filt_q[0];
        for (int r = 0; r < NUM_FILT; r++) begin
            frow_s = (r == filt_r_s) ? filt_q[r] : frow_s;
        end
        fpad_s = {(NWORDS*32){1'b0}};
        fpad_s[WIDTH-1:0] = frow_s;
        if (filt_w_s < NWORDS) begin
            fword_s = fpad_s[filt_w_s*32 +: 32];
        end else begin
            fword_s = 32'h0000_0000;
        end
    end

    // Read data multiplexer.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (slave_address)
            A_CTRL:   rdata_s = {29'h0, frz_q, en_q, active_s};
            A_STATUS: rdata_s = {{(32-NUM_CH){1'b0}}, flags_q};
            A_SYSVER: rdata_s = 32'(SYS_VERSION);
            A_CHSEL:  rdata_s = {28'h0, chsel_q};
            A_DLO:    rdata_s = dat_sel_s[31:0];
            A_DHI:    rdata_s = dat_hi_q;
            A_ELO:    rdata_s = err_sel_s[31:0];
            A_EHI:    rdata_s = err_hi_q;
            A_DELAY:  rdata_s = i_dut_delay;
            A_FSEL:   rdata_s = {31'h0, fsel_q};
            default:  rdata_s = filt_hit_s ? fword_s : 32'h0000_0000;
        endcase
    end

    // Next-state for control, status, snapshot and read-return registers.
    always_comb begin
        en_d     = (wr_s && slave_address == A_CTRL && slave_byteenable[0])
                 ? slave_writedata[CTRL_EN_BIT] : en_q;
        frz_d    = (wr_s && slave_address == A_CTRL && slave_byteenable[0])
                 ? slave_writedata[CTRL_FRZ_BIT] : frz_q;
        chsel_d  = (wr_s && slave_address == A_CHSEL && slave_byteenable[0])
                 ? slave_writedata[3:0] : chsel_q;
        fsel_d   = (wr_s && slave_address == A_FSEL && slave_byteenable[0])
                 ? slave_writedata[0] : fsel_q;
        clr_s    = (wr_s && slave_address == A_STATUS)
                 ? (slave_writedata[NUM_CH-1:0] & mask_s[NUM_CH-1:0]) : {NUM_CH{1'b0}};
        // Set after clear so a same-cycle event keeps the flag.
        flags_d  = (flags_q & ~clr_s) | i_err_pulse;
        // A LO read captures the matching upper half for a later atomic HI read.
        dat_hi_d = (rd_s && slave_address == A_DLO) ? dat_sel_s[63:32] : dat_hi_q;
        err_hi_d = (rd_s && slave_address == A_ELO) ? err_sel_s[63:32] : err_hi_q;
        rdata_d  = rd_s ? rdata_s : rdata_q;
        rvalid_d = rd_s;
    end

    // Filter register write with per-byte enables; bits at or above WIDTH do not exist.
    always_comb begin
        for (int r = 0; r < NUM_FILT; r++) begin
            filt_d[r] = filt_q[r];
        end
        for (int r = 0; r < NUM_FILT; r++) begin
            for (int i = 0; i < WIDTH; i++) begin
                filt_d[r][i] = (wr_s && filt_hit_s && filt_r_s == r && filt_w_s == i / 32
                                && mask_s[i % 32]) ? slave_writedata[i % 32] : filt_q[r][i];
            end
        end
    end

    // Register update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b0;
            frz_q    <= 1'b0;
            fsel_q   <= 1'b0;
            chsel_q  <= 4'h0;
            flags_q  <= {NUM_CH{1'b0}};
            dat_hi_q <= 32'h0000_0000;
            err_hi_q <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            rvalid_q <= 1'b0;
            for (int r = 0; r < NUM_FILT; r++) begin
                filt_q[r] <= {WIDTH{1'b0}};
            end
        end else begin
            en_q     <= en_d;
            frz_q    <= frz_d;
            fsel_q   <= fsel_d;
            chsel_q  <= chsel_d;
            flags_q  <= flags_d;
            dat_hi_q <= dat_hi_d;
            err_hi_q <= err_hi_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            for (int r = 0; r < NUM_FILT; r++) begin
                filt_q[r] <= filt_d[r];
            end
        end
    end

    assign slave_readdata      = rdata_q;
    assign slave_readdatavalid = rvalid_q;
    assign tb_reset            = pulse_s;
    // The stored EN bit survives the pulse; only the output is held low.
    assign tb_enable           = en_q & ~pulse_s;
    assign tb_freeze           = frz_q;
    assign o_fselect           = fsel_q;
    assign o_fmanual_a         = filt_q[FILT_MANUAL_A];
    assign o_fmanual_b         = filt_q[FILT_MANUAL_B];
    assign o_fbitset_a         = filt_q[FILT_BITSET_A];
    assign o_fbitset_b         = filt_q[FILT_BITSET_B];
    assign o_fbitclr_a         = filt_q[FILT_BITCLR_A];
    assign o_fbitclr_b         = filt_q[FILT_BITCLR_B];

endmodule

// File: tb/tb_tb_csr_bank.sv
// Self-checking bench for tb_csr_bank: a register-level model advanced once per
// clock, a per-cycle compare process, and directed scenarios with literal values.
module tb_tb_csr_bank;

    localparam int WIDTH      = 64;
    localparam int NUM_CH     = 4;
    localparam int RST_CYCLES = 8;
    localparam int ADDR_W     = 8;
    localparam int NW         = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ADDR_W-1:0]    slave_address;
    logic                 slave_read, slave_write;
    logic [31:0]          slave_writedata;
    logic [3:0]           slave_byteenable;
    logic [31:0]          slave_readdata;
    logic                 slave_readdatavalid;
    logic                 tb_reset, tb_enable, tb_freeze;
    logic [NUM_CH*64-1:0] i_data_ctr, i_event_ctr;
    logic [31:0]          i_dut_delay;
    logic [NUM_CH-1:0]    i_err_pulse;
    logic                 o_fselect;
    logic [WIDTH-1:0]     o_fmanual_a, o_fmanual_b, o_fbitset_a, o_fbitset_b, o_fbitclr_a, o_fbitclr_b;

    always #5 clk = ~clk;

    tb_csr_bank #(.SYS_VERSION(21), .WIDTH(WIDTH), .NUM_CH(NUM_CH),
                  .RST_CYCLES(RST_CYCLES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
        .slave_writedata(slave_writedata), .slave_byteenable(slave_byteenable),
        .slave_readdata(slave_readdata), .slave_readdatavalid(slave_readdatavalid),
        .tb_reset(tb_reset), .tb_enable(tb_enable), .tb_freeze(tb_freeze),
        .i_data_ctr(i_data_ctr), .i_event_ctr(i_event_ctr), .i_dut_delay(i_dut_delay),
        .i_err_pulse(i_err_pulse), .o_fselect(o_fselect),
        .o_fmanual_a(o_fmanual_a), .o_fmanual_b(o_fmanual_b),
        .o_fbitset_a(o_fbitset_a), .o_fbitset_b(o_fbitset_b),
        .o_fbitclr_a(o_fbitclr_a), .o_fbitclr_b(o_fbitclr_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic              m_en, m_frz, m_fsel, m_rvalid, run_chk;
    logic [3:0]        m_chsel;
    logic [NUM_CH-1:0] m_flags;
    logic [31:0]       m_dhi, m_ehi, m_rdata;
    logic [63:0]       m_filt [6];
    int                m_left;   // remaining tb_reset cycles

    task automatic m_reset();
        m_en = 1'b0; m_frz = 1'b0; m_fsel = 1'b0; m_rvalid = 1'b0;
        m_chsel = 4'h0; m_flags = '0; m_dhi = 32'h0; m_ehi = 32'h0; m_rdata = 32'h0;
        m_left = 0;
        for (int r = 0; r < 6; r++) m_filt[r] = 64'h0;
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic int m_ch();
        return (int'(m_chsel) < NUM_CH) ? int'(m_chsel) : 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [63:0] dc, ec;
        int off;
        dc = i_data_ctr[m_ch()*64 +: 64];
        ec = i_event_ctr[m_ch()*64 +: 64];
        off = int'(a) - 16;
        case (a)
            8'h00: return {29'd0, m_frz, m_en, (m_left > 0)};
            8'h01: return 32'(m_flags);
            8'h02: return 32'd21;
            8'h03: return {28'd0, m_chsel};
            8'h04: return dc[31:0];
            8'h05: return m_dhi;
            8'h06: return ec[31:0];
            8'h07: return m_ehi;
            8'h08: return i_dut_delay;
            8'h09: return {31'd0, m_fsel};
            default: begin
                if (off >= 0 && off / 8 < 6 && off % 8 < NW)
                    return m_filt[off / 8][(off % 8)*32 +: 32];
                return 32'd0;
            end
        endcase
    endfunction

    // One clock edge of the model, from the inputs the DUT sampled.
    task automatic m_step();
        logic rdv, wrv;
        logic [7:0] a;
        logic [31:0] rv, clr, wd, mk;
        logic [63:0] dc, ec;
        int off;
        a   = slave_address;
        wd  = slave_writedata;
        mk  = bmask(slave_byteenable);
        rdv = slave_read && !slave_write;
        wrv = slave_write && !slave_read;
        rv  = m_read(a);
        dc  = i_data_ctr[m_ch()*64 +: 64];
        ec  = i_event_ctr[m_ch()*64 +: 64];
        if (rdv && a == 8'h04) m_dhi = dc[63:32];
        if (rdv && a == 8'h06) m_ehi = ec[63:32];
        if (wrv && a == 8'h00 && slave_byteenable[0] && wd[0]) m_left = RST_CYCLES;
        else if (m_left > 0) m_left--;
        clr = 32'd0;
        if (wrv) begin
            case (a)
                8'h00: if (slave_byteenable[0]) begin m_en = wd[1]; m_frz = wd[2]; end
                8'h01: clr = wd & mk;
                8'h03: if (slave_byteenable[0]) m_chsel = wd[3:0];
                8'h09: if (slave_byteenable[0]) m_fsel = wd[0];
                default: begin
                    off = int'(a) - 16;
                    if (off >= 0 && off / 8 < 6 && off % 8 < NW)
                        m_filt[off / 8][(off % 8)*32 +: 32] =
                            (m_filt[off / 8][(off % 8)*32 +: 32] & ~mk) | (wd & mk);
                end
            endcase
        end
        m_flags  = (m_flags & ~clr[NUM_CH-1:0]) | i_err_pulse;
        m_rvalid = rdv;
        if (rdv) m_rdata = rv;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("readdatavalid", 64'(slave_readdatavalid), 64'(m_rvalid));
            if (m_rvalid) chk("readdata", 64'(slave_readdata), 64'(m_rdata));
            chk("tb_reset",  64'(tb_reset),  64'(m_left > 0));
            chk("tb_enable", 64'(tb_enable), 64'(m_en && m_left == 0));
            chk("tb_freeze", 64'(tb_freeze), 64'(m_frz));
            chk("o_fselect", 64'(o_fselect), 64'(m_fsel));
            chk("o_fmanual_a", o_fmanual_a, m_filt[0]);
            chk("o_fmanual_b", o_fmanual_b, m_filt[1]);
            chk("o_fbitset_a", o_fbitset_a, m_filt[2]);
            chk("o_fbitset_b", o_fbitset_b, m_filt[3]);
            chk("o_fbitclr_a", o_fbitclr_a, m_filt[4]);
            chk("o_fbitclr_b", o_fbitclr_b, m_filt[5]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        slave_address = a; slave_writedata = d; slave_byteenable = be;
        slave_write = 1'b1; slave_read = 1'b0;
        step();
        slave_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string name);
        slave_address = a; slave_read = 1'b1; slave_write = 1'b0;
        step();
        slave_read = 1'b0;
        chk(name, 64'(slave_readdata), 64'(exp));
        chk({name, "_valid"}, 64'(slave_readdatavalid), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"},  64'(slave_readdata), 64'd0);
        chk({tag, "_rvalid"}, 64'(slave_readdatavalid), 64'd0);
        chk({tag, "_tbrst"},  64'(tb_reset), 64'd0);
        chk({tag, "_tben"},   64'(tb_enable), 64'd0);
        chk({tag, "_frz"},    64'(tb_freeze), 64'd0);
        chk({tag, "_fsel"},   64'(o_fselect), 64'd0);
        chk({tag, "_filt"},   o_fmanual_a | o_fmanual_b | o_fbitset_a | o_fbitset_b
                              | o_fbitclr_a | o_fbitclr_b, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulse_cnt, guard;
        run_chk = 1'b0;
        reset = 1'b1;
        slave_address = '0; slave_read = 1'b0; slave_write = 1'b0;
        slave_writedata = 32'h0; slave_byteenable = 4'h0;
        i_data_ctr = '0; i_event_ctr = '0; i_dut_delay = 32'h0000_1234; i_err_pulse = '0;
        m_reset();
        @(negedge clk); @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        run_chk = 1'b1;
        idle(1);

        // SYSVER, then a quiet cycle so readdatavalid must drop.
        bus_rd(8'h02, 32'h0000_0015, "sysver");
        idle(1);
        chk("sysver_valid_drop", 64'(slave_readdatavalid), 64'd0);

        // Multi-word filter with a partial byte-lane write.
        bus_wr(8'h10, 32'h0000_0011, 4'hF);
        bus_wr(8'h11, 32'hAABB_CCDD, 4'hF);
        bus_wr(8'h10, 32'h0000_FF00, 4'b0010);
        chk("fmanual_a", o_fmanual_a, 64'hAABBCCDD_0000FF11);
        bus_rd(8'h11, 32'hAABB_CCDD, "fma_w1");
        bus_wr(8'h12, 32'hFFFF_FFFF, 4'hF);
        bus_rd(8'h12, 32'h0, "filt_unmapped_word");
        bus_wr(8'h39, 32'h1234_5678, 4'hF);
        chk("fbitclr_b", o_fbitclr_b, 64'h12345678_00000000);

        // Counter snapshots.
        bus_wr(8'h03, 32'h2, 4'hF);
        i_data_ctr[2*64 +: 64] = 64'h00000005_FFFFFFFF;
        bus_rd(8'h04, 32'hFFFF_FFFF, "datlo");
        i_data_ctr[2*64 +: 64] = 64'h00000006_00000000;
        bus_rd(8'h05, 32'h0000_0005, "dathi_snapshot");
        i_event_ctr[2*64 +: 64] = 64'h00000007_00000009;
        bus_rd(8'h06, 32'h9, "errlo");
        bus_rd(8'h07, 32'h7, "errhi");
        bus_rd(8'h05, 32'h5, "dathi_independent");
        bus_wr(8'h03, 32'hA, 4'hF);
        bus_rd(8'h03, 32'hA, "chsel_readback");
        i_data_ctr[0 +: 64] = 64'h00000003_00000004;
        bus_rd(8'h04, 32'h4, "chsel_oob_lo");
        bus_rd(8'h05, 32'h3, "chsel_oob_hi");

        // Sticky flags: set beats clear in the same cycle.
        i_err_pulse = 4'b0010;
        bus_wr(8'h01, 32'h2, 4'hF);
        i_err_pulse = 4'b0000;
        bus_rd(8'h01, 32'h2, "status_set_wins");
        bus_wr(8'h01, 32'h2, 4'hF);
        bus_rd(8'h01, 32'h0, "status_cleared");
        i_err_pulse = 4'b1001;
        idle(1);
        i_err_pulse = 4'b0000;
        bus_wr(8'h01, 32'h1, 4'h0);
        bus_rd(8'h01, 32'h9, "status_be_off");
        bus_wr(8'h01, 32'h1, 4'hF);
        bus_rd(8'h01, 32'h8, "status_partial_clear");

        // Reset pulse with extension.
        bus_wr(8'h00, 32'h3, 4'hF);
        pulse_cnt = tb_reset ? 1 : 0;
        chk("pulse_start", 64'(tb_reset), 64'd1);
        chk("pulse_en_low", 64'(tb_enable), 64'd0);
        idle(1);
        pulse_cnt += tb_reset ? 1 : 0;
        bus_rd(8'h00, 32'h3, "ctrl_during_pulse");
        pulse_cnt += tb_reset ? 1 : 0;
        bus_wr(8'h00, 32'h3, 4'hF);
        pulse_cnt += tb_reset ? 1 : 0;
        guard = 0;
        while (tb_reset && guard < 40) begin
            idle(1);
            guard++;
            pulse_cnt += tb_reset ? 1 : 0;
        end
        chk("pulse_bound", 64'(guard < 40), 64'd1);
        chk("pulse_len", 64'(pulse_cnt), 64'd11);
        chk("en_after_pulse", 64'(tb_enable), 64'd1);
        bus_rd(8'h00, 32'h2, "ctrl_after_pulse");
        bus_wr(8'h00, 32'h1, 4'h0);
        chk("ctrl_be_off_no_pulse", 64'(tb_reset), 64'd0);

        // Read and write together: ignored.
        slave_address = 8'h00; slave_writedata = 32'h5; slave_byteenable = 4'hF;
        slave_read = 1'b1; slave_write = 1'b1;
        step();
        slave_read = 1'b0; slave_write = 1'b0;
        chk("both_no_valid", 64'(slave_readdatavalid), 64'd0);
        chk("both_no_pulse", 64'(tb_reset), 64'd0);
        chk("both_no_frz", 64'(tb_freeze), 64'd0);
        bus_rd(8'h00, 32'h2, "ctrl_after_both");

        // Misc registers.
        bus_wr(8'h09, 32'h1, 4'hF);
        bus_rd(8'h09, 32'h1, "fselect");
        bus_wr(8'h02, 32'h0, 4'hF);
        bus_rd(8'h02, 32'h15, "sysver_ro");
        bus_rd(8'h0A, 32'h0, "unmapped");

        // Back-to-back reads.
        slave_address = 8'h02; slave_read = 1'b1;
        step();
        chk("b2b_first", 64'(slave_readdata), 64'h15);
        slave_address = 8'h08;
        step();
        slave_read = 1'b0;
        chk("b2b_second", 64'(slave_readdata), 64'h1234);
        chk("b2b_valid", 64'(slave_readdatavalid), 64'd1);

        // Async reset during a pulse with a read in flight.
        bus_wr(8'h00, 32'h1, 4'h1);
        slave_address = 8'h02; slave_read = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_chk = 1'b0;
        slave_read = 1'b0;
        @(negedge clk);
        chk_all_zero("inflight");
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        run_chk = 1'b1;
        idle(2);
        bus_rd(8'h05, 32'h0, "snapshot_after_reset");
        bus_rd(8'h01, 32'h0, "status_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_csr_bank.md
Name: tb_csr_bank

Overview:
- Avalon-MM slave register bank that controls and observes the arithmetic testbench; the next generation of the single-channel 32-bit wrapper.
- Supports operand widths above 32 bits through multi-word registers, NUM_CH monitor channels selected by an index register, and atomic 64-bit counter reads.
- Adds sticky write-1-to-clear error flags, a self-timed testbench reset pulse, byte enables and a fixed-latency readdatavalid.
- Sits between the HPS bridge and the testbench core, all on clk.

Parameters:
- SYS_VERSION, 21, value returned at SYSVER.
- WIDTH, 64, operand width; 1..256.
- NUM_CH, 4, monitor channels; 1..16.
- RST_CYCLES, 8, length of the tb_reset pulse in clk cycles; >=1.
- ADDR_W, 8, word-address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- slave_address  in  ADDR_W  word address.
- slave_read  in  1  read strobe.
- slave_write  in  1  write strobe.
- slave_writedata  in  32  write data.
- slave_byteenable  in  4  write byte lanes.
- slave_readdata  out  32  registered read data.
- slave_readdatavalid  out  1  read-data qualifier.
- tb_reset  out  1  testbench reset pulse.
- tb_enable  out  1  testbench enable.
- tb_freeze  out  1  counter freeze.
- i_data_ctr  in  NUM_CH*64  per-channel data counters; channel c occupies bits [c*64+63 : c*64].
- i_event_ctr  in  NUM_CH*64  per-channel error counters, same packing.
- i_dut_delay  in  32  measured DUT delay.
- i_err_pulse  in  NUM_CH  one-cycle error event per channel.
- o_fselect  out  1  filter select.
- o_fmanual_a, o_fmanual_b, o_fbitset_a, o_fbitset_b, o_fbitclr_a, o_fbitclr_b  out  WIDTH each  filter operands.

Behaviour:
- Bus qualification: write = slave_write & ~slave_read; read = slave_read & ~slave_write. If both strobes are high, the access is ignored: no state change and no readdatavalid.
- Read latency: slave_readdata is registered. slave_readdatavalid is high exactly one cycle after an accepted read. Back-to-back reads are supported, one per cycle.
- Unmapped or write-only addresses read 0x00000000. Writes to them, and to read-only addresses, are ignored.
- Byte enables apply to every writable register. Only the byte lanes with slave_byteenable set are updated.
- NW = ceil(WIDTH/32).
- Address map (word addresses):
  - 0x00 CTRL: bit0 RST, bit1 EN, bit2 FRZ.
  - 0x01 STATUS: bits [NUM_CH-1:0] sticky error flags, write-1-to-clear.
  - 0x02 SYSVER: read-only.
  - 0x03 CHSEL: bits [3:0], read/write.
  - 0x04 DATCTR_LO, 0x05 DATCTR_HI.
  - 0x06 ERRCTR_LO, 0x07 ERRCTR_HI.
  - 0x08 DUTDELAY: read-only.
  - 0x09 FSELECT: bit0.
  - 0x10 + 8*r + w: filter register r (0 = manual_a, 1 = manual_b, 2 = bitset_a, 3 = bitset_b, 4 = bitclr_a, 5 = bitclr_b), word w, for w < NW. Word 0 is least significant. Words at w >= NW are unmapped.
- Top filter word: bits at or above WIDTH are not stored and read as 0.
- CHSEL range: values >= NUM_CH select channel 0 for counter reads. The register still reads back the value as written.
- Counter snapshot:
  - A read of a LO address returns bits [31:0] of the selected channel's counter.
  - The same read latches bits [63:32] of that counter into the matching HI snapshot register.
  - A HI read returns the snapshot, which is 0 after reset.
  - The data and error counters have independent snapshots.
- STATUS sticky flags:
  - Flag c sets on i_err_pulse[c].
  - Writing 1 to bit c clears it.
  - If a set and a clear hit the same cycle, the set wins.
- Reset pulse generator, two states, IDLE and PULSE:
  - IDLE -> PULSE: a CTRL write with byteenable[0]=1 and writedata[0]=1. The down-counter loads RST_CYCLES.
  - PULSE: tb_reset=1 and the counter decrements each cycle; return to IDLE when it reaches 1.
  - Another RST write during PULSE reloads the counter, extending the pulse.
  - CTRL bit0 reads 1 while in PULSE and is never stored.
  - tb_enable is forced to 0 during PULSE; the stored EN bit is preserved.
- Async reset:
  - Clears all registers, flags and snapshots; the FSM returns to IDLE.
  - All outputs are 0, including slave_readdatavalid and tb_reset.
  - A read in flight at reset is dropped.

Decomposition:
- Package tb_csr_pkg holds:
  - address constants (CTRL_ADDR .. FSELECT_ADDR, FILT_BASE = 8'h10, FILT_STRIDE = 8);
  - CTRL bit indices;
  - filter index constants;
  - an NW function.
- One sub-module, tb_rst_pulse, holds the IDLE/PULSE FSM and counter. Inputs: clk, reset, trigger. Outputs: pulse, active.

Test Plan:
- Reset, then read SYSVER -> readdata 0x15 with readdatavalid exactly 1 cycle after the read; all outputs 0 while reset is high.
- WIDTH=64: write 0x11 to word 0 and 0xAABBCCDD to word 1 of manual_a, then write word 0 with byteenable 4'b0010 and data 0x0000FF00 -> o_fmanual_a = 0xAABBCCDD0000FF11.
- CHSEL=2, i_data_ctr channel 2 = 0x00000005_FFFFFFFF; read LO; change the input to 0x6_00000000; read HI -> LO returned 0xFFFFFFFF, HI returns 0x5.
- Pulse i_err_pulse[1] and, in the same cycle, write STATUS 0x2 -> STATUS reads 0x2; a second write of 0x2 -> STATUS reads 0x0.
- Write CTRL 0x3, then write 0x3 again 3 cycles later -> tb_reset high for 3+8 cycles, tb_enable 0 throughout the pulse then 1, CTRL bit0 reads 1 during the pulse.
- Assert read and write together at 0x00 -> no register change and no readdatavalid.
